// File: rtl/lc3_mem_responder.sv
// Memory and memory-mapped I/O responder for the LC-3 core, with programmable wait states before R.
// Optional feature: define LC3_KBD_IRQ_EN to enable KBSR[14] and the registered keyboard interrupt.
module lc3_mem_responder #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_in,
    output logic [15:0] mem_out,
    output logic        r,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_char,
    output logic        disp_valid,
    output logic [7:0]  disp_char,
    input  logic        disp_ack,
    output logic        mcr_run,
    output logic        kbd_irq
);

    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;
    localparam logic [15:0] DEV_BASE  = 16'hFE00;
    localparam logic [3:0]  LAST_WAIT = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [15:0] req_addr;
    logic [15:0] req_data;
    logic        req_write;

    logic [15:0] mem [2**ADDR_W];

    logic        kbsr_ready;
    logic        kbsr_ie;
    logic [7:0]  kbdr;
    logic        dsr_ready;

    logic [15:0] rd_addr;
    logic [15:0] rd_value;
    logic        commit;
    logic        kbdr_rd;
    logic        ddr_wr;
    logic        mcr_wr;
    logic        mem_wr;

    // With zero wait states the read value is captured straight from mar in IDLE.
    always_comb begin
        rd_addr  = (state == IDLE) ? mar : req_addr;
        rd_value = 16'h0000;
        if (rd_addr >= DEV_BASE) begin
            case (rd_addr)
                KBSR_ADDR: rd_value = {kbsr_ready, kbsr_ie, 14'h0000};
                KBDR_ADDR: rd_value = {8'h00, kbdr};
                DSR_ADDR:  rd_value = {dsr_ready, 15'h0000};
                MCR_ADDR:  rd_value = {mcr_run, 15'h0000};
                default:   rd_value = 16'h0000;
            endcase
        end else begin
            rd_value = mem[rd_addr[ADDR_W-1:0]];
        end
    end

    assign commit  = (state == READY);
    assign kbdr_rd = commit && !req_write && (req_addr == KBDR_ADDR);
    assign ddr_wr  = commit && req_write && (req_addr == DDR_ADDR);
    assign mcr_wr  = commit && req_write && (req_addr == MCR_ADDR);
    assign mem_wr  = commit && req_write && (req_addr < DEV_BASE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            r         <= 1'b0;
            mem_out   <= 16'h0000;
            req_addr  <= 16'h0000;
            req_data  <= 16'h0000;
            req_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mio_en) begin
                        req_addr  <= mar;
                        req_data  <= mdr_in;
                        req_write <= r_w;
                        wait_cnt  <= 4'd0;
                        if (WAIT_CYCLES == 0) begin
                            state <= READY;
                            r     <= 1'b1;
                            if (!r_w) begin
                                mem_out <= rd_value;
                            end
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        state <= READY;
                        r     <= 1'b1;
                        if (!req_write) begin
                            mem_out <= rd_value;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                READY: begin
                    state <= IDLE;
                    r     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    r     <= 1'b0;
                end
            endcase
        end
    end

    // Memory has no reset; gating on reset_n keeps an aborted request from writing.
    always_ff @(posedge clock) begin
        if (reset_n && mem_wr) begin
            mem[req_addr[ADDR_W-1:0]] <= req_data;
        end
    end

    // A new keyboard char beats the KBDR-read clear; a DDR write beats disp_ack.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            kbsr_ready <= 1'b0;
            kbdr       <= 8'h00;
            dsr_ready  <= 1'b1;
            disp_char  <= 8'h00;
            disp_valid <= 1'b0;
            mcr_run    <= 1'b1;
        end else begin
            disp_valid <= ddr_wr;
            if (kbd_valid && (!kbsr_ready || kbdr_rd)) begin
                kbdr       <= kbd_char;
                kbsr_ready <= 1'b1;
            end else if (kbdr_rd) begin
                kbsr_ready <= 1'b0;
            end
            if (ddr_wr) begin
                disp_char <= req_data[7:0];
                dsr_ready <= 1'b0;
            end else if (disp_ack) begin
                dsr_ready <= 1'b1;
            end
            if (mcr_wr) begin
                mcr_run <= req_data[15];
            end
        end
    end

`ifdef LC3_KBD_IRQ_EN
    logic kbsr_wr;
    assign kbsr_wr = commit && req_write && (req_addr == KBSR_ADDR);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            kbsr_ie <= 1'b0;
            kbd_irq <= 1'b0;
        end else begin
            if (kbsr_wr) begin
                kbsr_ie <= req_data[14];
            end
            kbd_irq <= kbsr_ready & kbsr_ie;
        end
    end
`else
    assign kbsr_ie = 1'b0;
    assign kbd_irq = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder (ADDR_W=12, WAIT_CYCLES=2); covers both LC3_KBD_IRQ_EN builds.
module tb_lc3_mem_responder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        mio_en;
    logic        r_w;
    logic [15:0] mar;
    logic [15:0] mdr_in;
    logic [15:0] mem_out;
    logic        r;
    logic        kbd_valid;
    logic [7:0]  kbd_char;
    logic        disp_valid;
    logic [7:0]  disp_char;
    logic        disp_ack;
    logic        mcr_run;
    logic        kbd_irq;

    int tests = 0;
    int fails = 0;

    lc3_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(2)) dut (
        .clock(clock), .reset_n(reset_n), .mio_en(mio_en), .r_w(r_w),
        .mar(mar), .mdr_in(mdr_in), .mem_out(mem_out), .r(r),
        .kbd_valid(kbd_valid), .kbd_char(kbd_char), .disp_valid(disp_valid),
        .disp_char(disp_char), .disp_ack(disp_ack), .mcr_run(mcr_run), .kbd_irq(kbd_irq)
    );

    always #5 clock = ~clock;

    // Issues one request, optionally strobes kbd_valid/disp_ack in the READY cycle, returns one cycle after R.
    task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                                 input logic kbd_at_ready, input logic [7:0] kch, input logic ack_at_ready,
                                 output logic [15:0] rdata, output int lat);
        @(negedge clock);
        mio_en = 1'b1; r_w = wr; mar = addr; mdr_in = data;
        @(posedge clock);
        lat = 0;
        rdata = 16'hxxxx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (r === 1'b1) begin
                lat = i;
                rdata = mem_out;
                break;
            end
        end
        mio_en = 1'b0;
        kbd_valid = kbd_at_ready;
        if (kbd_at_ready) kbd_char = kch;
        disp_ack = ack_at_ready;
        @(negedge clock);
        kbd_valid = 1'b0;
        disp_ack = 1'b0;
    endtask

    task automatic pulse_kbd(input logic [7:0] ch);
        @(negedge clock);
        kbd_valid = 1'b1; kbd_char = ch;
        @(negedge clock);
        kbd_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] d;
        int lat;
        tests++; if (r !== 1'b0) begin fails++; $display("[TB] FAIL reset_r: got %b expected 0", r); end
        tests++; if (mem_out !== 16'h0000) begin fails++; $display("[TB] FAIL reset_mem_out: got %h expected 0000", mem_out); end
        tests++; if (disp_valid !== 1'b0 || disp_char !== 8'h00) begin fails++; $display("[TB] FAIL reset_disp: got %b/%h expected 0/00", disp_valid, disp_char); end
        tests++; if (mcr_run !== 1'b1 || kbd_irq !== 1'b0) begin fails++; $display("[TB] FAIL reset_mcr_irq: got %b/%b expected 1/0", mcr_run, kbd_irq); end
        applyStimulus(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h0000) begin fails++; $display("[TB] FAIL reset_kbsr: got %h expected 0000", d); end
        applyStimulus(1'b0, 16'hFE02, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h0000) begin fails++; $display("[TB] FAIL reset_kbdr: got %h expected 0000", d); end
        applyStimulus(1'b0, 16'hFE04, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h8000) begin fails++; $display("[TB] FAIL reset_dsr: got %h expected 8000", d); end
        applyStimulus(1'b0, 16'hFFFE, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h8000) begin fails++; $display("[TB] FAIL reset_mcr: got %h expected 8000", d); end
    endtask

    task automatic test_memory;
        logic [15:0] d;
        int lat;
        applyStimulus(1'b1, 16'h3000, 16'h1234, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (lat !== 3) begin fails++; $display("[TB] FAIL write_latency: got %0d expected 3", lat); end
        applyStimulus(1'b0, 16'h3000, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (lat !== 3) begin fails++; $display("[TB] FAIL read_latency: got %0d expected 3", lat); end
        tests++; if (d !== 16'h1234) begin fails++; $display("[TB] FAIL read_x3000: got %h expected 1234", d); end
        applyStimulus(1'b1, 16'h3002, 16'h5555, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h1234) begin fails++; $display("[TB] FAIL mem_out_hold: got %h expected 1234", d); end
        applyStimulus(1'b1, 16'h4005, 16'hBEEF, 1'b0, 8'h0, 1'b0, d, lat);
        applyStimulus(1'b0, 16'h0005, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'hBEEF) begin fails++; $display("[TB] FAIL wrap_x0005: got %h expected beef", d); end
        applyStimulus(1'b0, 16'hFE08, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h0000) begin fails++; $display("[TB] FAIL unmapped_xfe08: got %h expected 0000", d); end
        applyStimulus(1'b0, 16'h3002, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h5555) begin fails++; $display("[TB] FAIL read_x3002: got %h expected 5555", d); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] d;
        int lat1 = 0;
        int lat2 = 0;
        @(negedge clock);
        mio_en = 1'b1; r_w = 1'b1; mar = 16'h3010; mdr_in = 16'h1111;
        @(posedge clock);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (r === 1'b1) begin lat1 = i; break; end
        end
        mar = 16'h3011; mdr_in = 16'h2222;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (r === 1'b1) begin lat2 = i; break; end
        end
        mio_en = 1'b0;
        @(negedge clock);
        tests++; if (lat1 !== 3) begin fails++; $display("[TB] FAIL b2b_first_latency: got %0d expected 3", lat1); end
        tests++; if (lat2 !== 4) begin fails++; $display("[TB] FAIL b2b_second_latency: got %0d expected 4", lat2); end
        applyStimulus(1'b0, 16'h3010, 16'h0, 1'b0, 8'h0, 1'b0, d, lat1);
        tests++; if (d !== 16'h1111) begin fails++; $display("[TB] FAIL b2b_x3010: got %h expected 1111", d); end
        applyStimulus(1'b0, 16'h3011, 16'h0, 1'b0, 8'h0, 1'b0, d, lat1);
        tests++; if (d !== 16'h2222) begin fails++; $display("[TB] FAIL b2b_x3011: got %h expected 2222", d); end
    endtask

    task automatic test_keyboard;
        logic [15:0] d;
        int lat;
        pulse_kbd(8'h41);
        applyStimulus(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h8000) begin fails++; $display("[TB] FAIL kbsr_after_char: got %h expected 8000", d); end
        pulse_kbd(8'h42);
        applyStimulus(1'b0, 16'hFE02, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h0041) begin fails++; $display("[TB] FAIL kbdr_read_a: got %h expected 0041", d); end
        applyStimulus(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h0000) begin fails++; $display("[TB] FAIL kbsr_cleared: got %h expected 0000", d); end
        pulse_kbd(8'h43);
        applyStimulus(1'b0, 16'hFE02, 16'h0, 1'b1, 8'h44, 1'b0, d, lat);
        tests++; if (d !== 16'h0043) begin fails++; $display("[TB] FAIL kbdr_read_c: got %h expected 0043", d); end
        applyStimulus(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h8000) begin fails++; $display("[TB] FAIL kbsr_new_wins: got %h expected 8000", d); end
        applyStimulus(1'b0, 16'hFE02, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h0044) begin fails++; $display("[TB] FAIL kbdr_read_d: got %h expected 0044", d); end
    endtask

    task automatic test_display;
        logic [15:0] d;
        int lat;
        applyStimulus(1'b1, 16'hFE06, 16'h0048, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (disp_valid !== 1'b1 || disp_char !== 8'h48) begin fails++; $display("[TB] FAIL ddr_pulse: got %b/%h expected 1/48", disp_valid, disp_char); end
        @(negedge clock);
        tests++; if (disp_valid !== 1'b0) begin fails++; $display("[TB] FAIL ddr_pulse_width: got %b expected 0", disp_valid); end
        applyStimulus(1'b0, 16'hFE04, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h0000) begin fails++; $display("[TB] FAIL dsr_busy: got %h expected 0000", d); end
        @(negedge clock); disp_ack = 1'b1;
        @(negedge clock); disp_ack = 1'b0;
        applyStimulus(1'b0, 16'hFE04, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h8000) begin fails++; $display("[TB] FAIL dsr_after_ack: got %h expected 8000", d); end
        applyStimulus(1'b1, 16'hFE06, 16'h0049, 1'b0, 8'h0, 1'b1, d, lat);
        applyStimulus(1'b0, 16'hFE04, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h0000) begin fails++; $display("[TB] FAIL dsr_write_wins: got %h expected 0000", d); end
        applyStimulus(1'b1, 16'hFE06, 16'h004A, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (disp_valid !== 1'b1 || disp_char !== 8'h4A) begin fails++; $display("[TB] FAIL ddr_overwrite: got %b/%h expected 1/4a", disp_valid, disp_char); end
    endtask

    task automatic test_mcr_abort;
        logic [15:0] d;
        int lat;
        logic saw_r = 1'b0;
        applyStimulus(1'b1, 16'hFFFE, 16'h0000, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (mcr_run !== 1'b0) begin fails++; $display("[TB] FAIL mcr_run_clear: got %b expected 0", mcr_run); end
        applyStimulus(1'b0, 16'hFFFE, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h0000) begin fails++; $display("[TB] FAIL mcr_read: got %h expected 0000", d); end
        applyStimulus(1'b1, 16'h3001, 16'hAAAA, 1'b0, 8'h0, 1'b0, d, lat);
        @(negedge clock);
        mio_en = 1'b1; r_w = 1'b1; mar = 16'h3001; mdr_in = 16'h7777;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0; mio_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i == 1) reset_n = 1'b1;
            if (r !== 1'b0) saw_r = 1'b1;
        end
        tests++; if (saw_r !== 1'b0) begin fails++; $display("[TB] FAIL abort_no_r: got %b expected 0", saw_r); end
        tests++; if (mcr_run !== 1'b1) begin fails++; $display("[TB] FAIL abort_mcr_run: got %b expected 1", mcr_run); end
        applyStimulus(1'b0, 16'h3001, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'hAAAA) begin fails++; $display("[TB] FAIL abort_x3001: got %h expected aaaa", d); end
    endtask

    task automatic test_irq;
        logic [15:0] d;
        int lat;
`ifdef LC3_KBD_IRQ_EN
        applyStimulus(1'b1, 16'hFE00, 16'h4000, 1'b0, 8'h0, 1'b0, d, lat);
        applyStimulus(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h4000) begin fails++; $display("[TB] FAIL kbsr_ie_read: got %h expected 4000", d); end
        pulse_kbd(8'h5A);
        tests++; if (kbd_irq !== 1'b0) begin fails++; $display("[TB] FAIL irq_lag: got %b expected 0", kbd_irq); end
        @(negedge clock);
        tests++; if (kbd_irq !== 1'b1) begin fails++; $display("[TB] FAIL irq_set: got %b expected 1", kbd_irq); end
        applyStimulus(1'b0, 16'hFE02, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        @(negedge clock);
        tests++; if (kbd_irq !== 1'b0) begin fails++; $display("[TB] FAIL irq_clear: got %b expected 0", kbd_irq); end
`else
        pulse_kbd(8'h5A);
        applyStimulus(1'b1, 16'hFE00, 16'h4000, 1'b0, 8'h0, 1'b0, d, lat);
        applyStimulus(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h8000) begin fails++; $display("[TB] FAIL kbsr_no_ie: got %h expected 8000", d); end
        tests++; if (kbd_irq !== 1'b0) begin fails++; $display("[TB] FAIL irq_tied: got %b expected 0", kbd_irq); end
        applyStimulus(1'b0, 16'hFE02, 16'h0, 1'b0, 8'h0, 1'b0, d, lat);
        tests++; if (d !== 16'h005A) begin fails++; $display("[TB] FAIL kbdr_read_z: got %h expected 005a", d); end
`endif
    endtask

    initial begin
        reset_n = 1'b0; mio_en = 1'b0; r_w = 1'b0; mar = 16'h0; mdr_in = 16'h0;
        kbd_valid = 1'b0; kbd_char = 8'h0; disp_ack = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        test_reset();
        test_memory();
        test_back_to_back();
        test_keyboard();
        test_display();
        test_mcr_abort();
        test_irq();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
